// File: rtl/seg_display_sched.sv
// Round-robin display scheduler: grants one requesting source, converts its value to BCD
// with a sequential shift-add-3 engine and drives active-low seven-segment patterns.
module seg_display_sched #(
  parameter int N_SRC    = 3,
  parameter int VAL_W    = 13,
  parameter int DIGITS   = 4,
  parameter int HOLD_CYC = 50000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           i_req,
  input  logic [N_SRC*VAL_W-1:0]     i_val,
  output logic [DIGITS*7-1:0]        o_seg,
  output logic [$clog2(N_SRC)-1:0]   o_src,
  output logic                       o_valid,
  output logic                       o_busy
);

  localparam int SRC_W  = $clog2(N_SRC);
  localparam int HOLD_W = $clog2(HOLD_CYC);
  localparam int ITER_W = $clog2(VAL_W + 1);
  localparam int BCD_W  = 4 * DIGITS;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] DISP_LIMIT = pow10(DIGITS);

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1011000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  state_t             state_reg, state_next;
  logic [SRC_W-1:0]   last_src_reg;
  logic [VAL_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [ITER_W-1:0]  iter_reg;
  logic [HOLD_W-1:0]  hold_reg;
  logic               ovf_reg;

  logic               grant_en, step_en, load_en, clear_en;
  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  int                 search_idx;
  logic [VAL_W-1:0]   sel_val;
  logic [63:0]        sel_val_ext;
  logic [BCD_W-1:0]   bcd_adj;
  logic [DIGITS*7-1:0] seg_fmt;
  logic               lead_zero;

  // Rotating-priority search starting just after the last granted source.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = 0;
    for (int i = 1; i <= N_SRC; i++) begin
      search_idx = (int'(last_src_reg) + i) % N_SRC;
      if (!grant_found && i_req[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(search_idx);
      end
    end
  end

  always_comb begin
    sel_val = i_val[int'(grant_idx)*VAL_W +: VAL_W];
    sel_val_ext = '0;
    sel_val_ext[VAL_W-1:0] = sel_val;
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
  end

  // Leading zeros blank out from the top; the units digit is always drawn.
  always_comb begin
    seg_fmt   = '1;
    lead_zero = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (ovf_reg) begin
        seg_fmt[d*7 +: 7] = SEG_DASH;
      end else if (lead_zero && (d != 0) && (bcd_reg[d*4 +: 4] == 4'd0)) begin
        seg_fmt[d*7 +: 7] = SEG_BLANK;
      end else begin
        seg_fmt[d*7 +: 7] = seg_of(bcd_reg[d*4 +: 4]);
        lead_zero = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    grant_en   = 1'b0;
    step_en    = 1'b0;
    load_en    = 1'b0;
    clear_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          grant_en   = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (iter_reg == ITER_W'(VAL_W)) begin
          load_en    = 1'b1;
          state_next = SHOW;
        end else begin
          step_en = 1'b1;
        end
      end
      SHOW: begin
        if (!i_req[o_src]) begin
          clear_en   = 1'b1;
          state_next = IDLE;
        end else if (hold_reg == HOLD_W'(HOLD_CYC - 1)) begin
          // The shown source is still requesting, so a grant always exists here.
          grant_en   = 1'b1;
          state_next = CONV;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_src_reg <= SRC_W'(N_SRC - 1);
      o_src        <= '0;
      o_seg        <= '1;
      o_valid      <= 1'b0;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      iter_reg     <= '0;
      hold_reg     <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      if (grant_en) begin
        last_src_reg <= grant_idx;
        o_src        <= grant_idx;
        bin_reg      <= sel_val;
        bcd_reg      <= '0;
        iter_reg     <= '0;
        ovf_reg      <= (sel_val_ext >= DISP_LIMIT);
      end
      if (step_en) begin
        bcd_reg  <= {bcd_adj[BCD_W-2:0], bin_reg[VAL_W-1]};
        bin_reg  <= {bin_reg[VAL_W-2:0], 1'b0};
        iter_reg <= iter_reg + ITER_W'(1);
      end
      if (load_en) begin
        o_seg    <= seg_fmt;
        o_valid  <= 1'b1;
        hold_reg <= '0;
      end
      if (clear_en) begin
        o_seg   <= '1;
        o_valid <= 1'b0;
      end
      if ((state_reg == SHOW) && (hold_reg != HOLD_W'(HOLD_CYC - 1)))
        hold_reg <= hold_reg + HOLD_W'(1);
    end
  end

  assign o_busy = (state_reg == CONV);

endmodule
